// File: rtl/lm32_addsub_pkg.sv
// Shared definitions for the LM32 add/sub scheduler.
// Holds the default adder width and the scheduler FSM state encodings.
// The encodings are plain localparams so older code that compares raw
// 2-bit state values keeps working.
package lm32_addsub_pkg;

    // Width of the shared combinational adder and of a narrow operand.
    localparam int ADDSUB_WIDTH = 32;

    // Scheduler FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/lm32_addsub_rr_arb.sv
// Two-way round-robin arbiter for the add/sub scheduler.
// Ports:
//   clk_i, rst_i        clock and asynchronous active-low reset
//   valid0_i, valid1_i  request lines from requester 0 and 1
//   advance_i           a grant was taken this cycle; rotate the priority
//   grant0_o, grant1_o  one-hot (or zero) grant for the current cycle
// A lone requester always wins. When both request, the one that was not
// granted last wins. After reset requester 0 is preferred.
module lm32_addsub_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic advance_i,
    output logic grant0_o,
    output logic grant1_o
);

    logic prefer1_q;
    logic prefer1_d;

    // Priority only matters on a tie, so the pointer just picks the tie winner.
    always_comb begin
        grant0_o  = valid0_i & (~valid1_i | ~prefer1_q);
        grant1_o  = valid1_i & (~valid0_i | prefer1_q);
        prefer1_d = prefer1_q;
        if (advance_i) begin
            prefer1_d = grant0_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prefer1_q <= 1'b0;
        end else begin
            prefer1_q <= prefer1_d;
        end
    end

endmodule

// File: rtl/lm32_addsub_sched.sv
// Scheduler that time-shares one external WIDTH-bit adder between two
// requesters. Narrow ops take one adder pass (LO); wide ops take two
// carry-chained passes (LO then HI). The result is held in RESP until the
// consumer takes it.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o  request handshake for requester N (0, 1)
//   reqN_a_i, reqN_b_i           2*WIDTH operands (upper half unused if narrow)
//   reqN_sub_i, reqN_wide_i      subtract select, 2*WIDTH op select
//   add_a_o, add_b_o, add_cin_o  drive to the external adder
//   add_result_i, add_cout_i     sum and carry from the external adder
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_id_o, rsp_result_o       issuing requester and the result
//   rsp_cout_o                   final carry (1 = no borrow on subtract)
module lm32_addsub_sched
    import lm32_addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [2*WIDTH-1:0]   req0_a_i,
    input  logic [2*WIDTH-1:0]   req0_b_i,
    input  logic                 req0_sub_i,
    input  logic                 req0_wide_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [2*WIDTH-1:0]   req1_a_i,
    input  logic [2*WIDTH-1:0]   req1_b_i,
    input  logic                 req1_sub_i,
    input  logic                 req1_wide_i,
    output logic [WIDTH-1:0]     add_a_o,
    output logic [WIDTH-1:0]     add_b_o,
    output logic                 add_cin_o,
    input  logic [WIDTH-1:0]     add_result_i,
    input  logic                 add_cout_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_id_o,
    output logic [2*WIDTH-1:0]   rsp_result_o,
    output logic                 rsp_cout_o
);

    logic [1:0]         state_q,  state_d;
    logic [2*WIDTH-1:0] a_q,      a_d;
    logic [2*WIDTH-1:0] b_q,      b_d;
    logic               sub_q,    sub_d;
    logic               wide_q,   wide_d;
    logic               id_q,     id_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q,  carry_d;

    logic grant0, grant1;
    logic in_idle, in_resp;
    logic hs0, hs1;

    // Readies are also gated by reset so nothing is offered while the
    // block is held in reset, even if a requester is already valid.
    assign in_idle      = (state_q == ST_IDLE) & rst_i;
    assign in_resp      = (state_q == ST_RESP);
    assign req0_ready_o = in_idle & grant0;
    assign req1_ready_o = in_idle & grant1;
    assign hs0          = req0_valid_i & req0_ready_o;
    assign hs1          = req1_valid_i & req1_ready_o;

    lm32_addsub_rr_arb u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid0_i  (req0_valid_i),
        .valid1_i  (req1_valid_i),
        .advance_i (hs0 | hs1),
        .grant0_o  (grant0),
        .grant1_o  (grant1)
    );

    // Response outputs are forced to zero outside RESP so reset and idle
    // cycles present a clean, all-zero port.
    assign rsp_valid_o  = in_resp;
    assign rsp_id_o     = in_resp & id_q;
    assign rsp_result_o = in_resp ? result_q : '0;
    assign rsp_cout_o   = in_resp & carry_q;

    // Adder drive: low halves with cin=sub in LO, high halves chained on
    // the LO carry in HI. Subtract is A + ~B + 1 across the whole op.
    always_comb begin
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
        case (state_q)
            ST_LO: begin
                add_a_o   = a_q[WIDTH-1:0];
                add_b_o   = sub_q ? ~b_q[WIDTH-1:0] : b_q[WIDTH-1:0];
                add_cin_o = sub_q;
            end
            ST_HI: begin
                add_a_o   = a_q[2*WIDTH-1:WIDTH];
                add_b_o   = sub_q ? ~b_q[2*WIDTH-1:WIDTH] : b_q[2*WIDTH-1:WIDTH];
                add_cin_o = carry_q;
            end
            default: begin
            end
        endcase
    end

    // Next-state and datapath capture. Operands are sampled only on the
    // accepting handshake; the result is cleared there so a narrow op
    // naturally returns a zero upper half.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        wide_d   = wide_q;
        id_d     = id_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (hs0 | hs1) begin
                    a_d      = hs1 ? req1_a_i    : req0_a_i;
                    b_d      = hs1 ? req1_b_i    : req0_b_i;
                    sub_d    = hs1 ? req1_sub_i  : req0_sub_i;
                    wide_d   = hs1 ? req1_wide_i : req0_wide_i;
                    id_d     = hs1;
                    result_d = '0;
                    carry_d  = 1'b0;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                result_d = {{WIDTH{1'b0}}, add_result_i};
                carry_d  = add_cout_i;
                state_d  = wide_q ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                result_d[2*WIDTH-1:WIDTH] = add_result_i;
                carry_d                   = add_cout_i;
                state_d                   = ST_RESP;
            end
            default: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            wide_q   <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            wide_q   <= wide_d;
            id_q     <= id_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

endmodule

// File: tb/tb_lm32_addsub_sched.sv
// Self-checking bench for lm32_addsub_sched. A transaction-level model
// tracks which op is outstanding, when its response is due and what the
// result must be (computed with plain 65/33-bit arithmetic), and a single
// negedge process compares every DUT output against it each cycle.
// Directed scenarios add a few literal expectations on top.
module tb_lm32_addsub_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic        req0_ready_o, req1_ready_o;
    logic [63:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic        req0_sub_i = 1'b0, req0_wide_i = 1'b0;
    logic        req1_sub_i = 1'b0, req1_wide_i = 1'b0;
    logic [31:0] add_a_o, add_b_o, add_result_i;
    logic        add_cin_o, add_cout_i;
    logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_id_o, rsp_cout_o;
    logic [63:0] rsp_result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // The external adder: a pure A+B+Cin.
    assign {add_cout_i, add_result_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {32'd0, add_cin_o};

    lm32_addsub_sched dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_sub_i   (req0_sub_i),
        .req0_wide_i  (req0_wide_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_sub_i   (req1_sub_i),
        .req1_wide_i  (req1_wide_i),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_cin_o    (add_cin_o),
        .add_result_i (add_result_i),
        .add_cout_i   (add_cout_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_cout_o   (rsp_cout_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: one outstanding op at most.
    bit          m_busy = 1'b0, m_prefer1 = 1'b0;
    int          m_cyc = 0, m_acc_cyc = 0;
    logic [63:0] m_a, m_bx, m_result;
    logic        m_sub, m_wide, m_id, m_cout, m_lo_carry;
    bit          e_idle, e_resp, e_lo, e_hi, e_g0, e_g1, e_take1;
    logic [31:0] e_a, e_b;
    logic        e_cin;
    logic [64:0] s65;
    logic [32:0] s33;

    // Compare process: inputs are stable around the negedge, so what is
    // sampled here is exactly what the DUT sees at the next posedge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            checkOutput("reset_outputs_zero",
                {63'd0, |{req0_ready_o, req1_ready_o, add_a_o, add_b_o, add_cin_o,
                          rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cout_o}}, 64'd0);
            m_busy    = 1'b0;
            m_prefer1 = 1'b0;
        end else begin
            e_idle = !m_busy;
            e_resp = m_busy && (m_cyc >= m_acc_cyc + (m_wide ? 3 : 2));
            e_lo   = m_busy && (m_cyc == m_acc_cyc + 1);
            e_hi   = m_busy && m_wide && (m_cyc == m_acc_cyc + 2);
            e_g0   = req0_valid_i && (!req1_valid_i || !m_prefer1);
            e_g1   = req1_valid_i && (!req0_valid_i || m_prefer1);
            checkOutput("req0_ready", 64'(req0_ready_o), 64'(e_idle && e_g0));
            checkOutput("req1_ready", 64'(req1_ready_o), 64'(e_idle && e_g1));
            checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(e_resp));
            e_a = '0; e_b = '0; e_cin = 1'b0;
            if (e_lo) begin
                e_a = m_a[31:0];  e_b = m_bx[31:0];  e_cin = m_sub;
            end
            if (e_hi) begin
                e_a = m_a[63:32]; e_b = m_bx[63:32]; e_cin = m_lo_carry;
            end
            checkOutput("add_a", 64'(add_a_o), 64'(e_a));
            checkOutput("add_b", 64'(add_b_o), 64'(e_b));
            checkOutput("add_cin", 64'(add_cin_o), 64'(e_cin));
            if (e_resp) begin
                checkOutput("rsp_id", 64'(rsp_id_o), 64'(m_id));
                checkOutput("rsp_result", rsp_result_o, m_result);
                checkOutput("rsp_cout", 64'(rsp_cout_o), 64'(m_cout));
            end
            if (e_idle && (e_g0 || e_g1)) begin
                e_take1   = e_g1;
                m_id      = e_take1;
                m_a       = e_take1 ? req1_a_i : req0_a_i;
                m_sub     = e_take1 ? req1_sub_i : req0_sub_i;
                m_wide    = e_take1 ? req1_wide_i : req0_wide_i;
                m_bx      = e_take1 ? req1_b_i : req0_b_i;
                if (m_sub) m_bx = ~m_bx;
                s33       = {1'b0, m_a[31:0]} + {1'b0, m_bx[31:0]} + 33'(m_sub);
                s65       = {1'b0, m_a} + {1'b0, m_bx} + 65'(m_sub);
                m_lo_carry = s33[32];
                m_result  = m_wide ? s65[63:0] : {32'd0, s33[31:0]};
                m_cout    = m_wide ? s65[64] : s33[32];
                m_busy    = 1'b1;
                m_acc_cyc = m_cyc;
                m_prefer1 = !e_take1;
            end else if (e_resp && rsp_ready_i) begin
                m_busy = 1'b0;
            end
        end
        m_cyc++;
    end

    // Offer one op from a single requester and return once it is accepted
    // (1 time unit after the accepting edge, i.e. during LO).
    task automatic applyStimulus(input bit who, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic wide);
        bit accepted = 1'b0;
        @(posedge clk_i); #1;
        if (!who) begin
            req0_a_i = a; req0_b_i = b; req0_sub_i = sub; req0_wide_i = wide; req0_valid_i = 1'b1;
        end else begin
            req1_a_i = a; req1_b_i = b; req1_sub_i = sub; req1_wide_i = wide; req1_valid_i = 1'b1;
        end
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk_i);
            if (who ? req1_ready_o : req0_ready_o) accepted = 1'b1;
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    // Count negedges until rsp_valid_o is seen; returns at that negedge.
    task automatic waitResponse(output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            lat++;
            if (rsp_valid_o) seen = 1'b1;
        end
        if (!seen) checkOutput("response_timeout", 64'd0, 64'd1);
    endtask

    // Hold both/one requester valid and record the order of grants.
    task automatic collectGrants(input bit v0, input bit v1, input int n, output logic [7:0] order);
        int got = 0;
        order = '0;
        @(posedge clk_i); #1;
        req0_a_i = 64'd10; req0_b_i = 64'd1; req0_sub_i = 1'b0; req0_wide_i = 1'b0;
        req1_a_i = 64'd20; req1_b_i = 64'd2; req1_sub_i = 1'b1; req1_wide_i = 1'b0;
        req0_valid_i = v0;
        req1_valid_i = v1;
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk_i);
            if (req0_ready_o && req0_valid_i) begin order[got] = 1'b0; got++; end
            else if (req1_ready_o && req1_valid_i) begin order[got] = 1'b1; got++; end
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        checkOutput("grant_count", 64'(got), 64'(n));
        repeat (6) @(posedge clk_i);
    endtask

    int          lat;
    logic [7:0]  order;

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Narrow add from requester 0.
        applyStimulus(1'b0, 64'h5, 64'h3, 1'b0, 1'b0);
        waitResponse(lat);
        checkOutput("narrow_add_latency", 64'(lat), 64'd2);
        checkOutput("narrow_add_result", rsp_result_o, 64'h0000_0000_0000_0008);
        checkOutput("narrow_add_cout", 64'(rsp_cout_o), 64'd0);
        checkOutput("narrow_add_id", 64'(rsp_id_o), 64'd0);

        // Narrow subtract with borrow from requester 1.
        applyStimulus(1'b1, 64'h1, 64'h2, 1'b1, 1'b0);
        waitResponse(lat);
        checkOutput("narrow_sub_result", rsp_result_o, 64'h0000_0000_FFFF_FFFF);
        checkOutput("narrow_sub_cout", 64'(rsp_cout_o), 64'd0);
        checkOutput("narrow_sub_id", 64'(rsp_id_o), 64'd1);

        // Wide add, carry crossing into the upper half.
        applyStimulus(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        checkOutput("wide_hi_cin", 64'(add_cin_o), 64'd1);
        waitResponse(lat);
        checkOutput("wide_latency", 64'(lat + 1), 64'd3);
        checkOutput("wide_result", rsp_result_o, 64'h0000_0001_0000_0000);
        checkOutput("wide_cout", 64'(rsp_cout_o), 64'd0);

        // Back-pressure: stall in RESP for 5 cycles.
        @(posedge clk_i); #1 rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 64'h1234, 64'h1111, 1'b0, 1'b0);
        waitResponse(lat);
        @(posedge clk_i); #1 req1_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("stall_valid", 64'(rsp_valid_o), 64'd1);
            checkOutput("stall_result", rsp_result_o, 64'h2345);
            checkOutput("stall_readies", 64'({req0_ready_o, req1_ready_o}), 64'd0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i  = 1'b1;
        req1_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("release_idle", 64'(rsp_valid_o), 64'd0);

        // Reset during HI of a wide op; outputs clear without a clock edge.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
            {63'd0, |{req0_ready_o, req1_ready_o, add_a_o, add_b_o, add_cin_o,
                      rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cout_o}}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Both valid continuously: grants alternate starting with requester 0.
        collectGrants(1'b1, 1'b1, 4, order);
        checkOutput("alternate_order", 64'(order[3:0]), 64'b1010);

        // Only requester 1 valid: it wins every time.
        collectGrants(1'b0, 1'b1, 3, order);
        checkOutput("single_order", 64'(order[2:0]), 64'b111);

        // Randomized traffic, including valid drops and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            req0_valid_i = ($urandom_range(0, 9) < 6);
            req1_valid_i = ($urandom_range(0, 9) < 6);
            req0_a_i     = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            req0_b_i     = {$urandom, $urandom};
            req1_a_i     = {$urandom, $urandom};
            req1_b_i     = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            req0_sub_i   = 1'($urandom_range(0, 1));
            req1_sub_i   = 1'($urandom_range(0, 1));
            req0_wide_i  = 1'($urandom_range(0, 1));
            req1_wide_i  = 1'($urandom_range(0, 1));
            rsp_ready_i  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        rsp_ready_i  = 1'b1;
        repeat (8) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lm32_addsub_sched.md
Name: lm32_addsub_sched

Overview:
- Time-shares one combinational 32-bit adder between two requesters (e.g. the execute-stage ALU and a multi-cycle arithmetic unit).
- Each request is a 32-bit add/sub, or a 64-bit add/sub executed as two carry-chained 32-bit passes.
- Round-robin arbitration on valid/ready; one result port with requester ID.
- The adder is external: a pure sum A+B+Cin returning result and carry.

Parameters:
- WIDTH, 32, adder and narrow-operand width; wide ops are 2*WIDTH.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  requester 0 has an op.
- req0_ready_o  out  1  scheduler accepts requester 0 this cycle.
- req0_a_i  in  2*WIDTH  operand A; upper half ignored when narrow.
- req0_b_i  in  2*WIDTH  operand B; upper half ignored when narrow.
- req0_sub_i  in  1  1 = A-B, 0 = A+B.
- req0_wide_i  in  1  1 = 64-bit op.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_sub_i, req1_wide_i  as above, for requester 1.
- add_a_o  out  WIDTH  adder input A.
- add_b_o  out  WIDTH  adder input B (already inverted for subtract).
- add_cin_o  out  1  adder carry-in.
- add_result_i  in  WIDTH  adder sum.
- add_cout_i  in  1  adder carry-out.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  consumer takes result.
- rsp_id_o  out  1  requester that issued the op.
- rsp_result_o  out  2*WIDTH  result.
- rsp_cout_o  out  1  final carry; for subtract, 1 = no borrow.

Behaviour:
- FSM states: IDLE, LO, HI, RESP. Reset (rst_i=0, any time, including mid-op) forces IDLE.
- Reset values: all outputs 0, all operand/result registers 0, rr pointer = requester 0 preferred.
- IDLE: reqN_ready_o asserted only here, and only for the granted requester. The other requester's ready is 0. Both readies are 0 outside IDLE.
- Grant rule: if only one valid, that one wins. If both valid, the requester not granted last wins; after reset, req0 wins.
- Handshake (valid & ready): latch A, B, sub, wide, id; toggle rr pointer to the other requester; go to LO.
- LO: add_a_o = A[WIDTH-1:0]; add_b_o = sub ? ~B[WIDTH-1:0] : B[WIDTH-1:0]; add_cin_o = sub.
  - Register the result into low half and add_cout_i into carry.
  - Go to HI if wide, else RESP (high half of result = 0).
- HI: add_a_o = A upper half; add_b_o = upper half of B, inverted if sub; add_cin_o = carry registered in LO.
  - Register the result into high half and add_cout_i into carry; go to RESP.
- RESP: rsp_valid_o=1; rsp_id_o, rsp_result_o and rsp_cout_o held stable.
  - On rsp_ready_i=1, go to IDLE. No new request is accepted in that same cycle.
- Adder outputs are driven to 0 in IDLE and RESP.
- Latency from accept to rsp_valid_o: narrow 2 cycles, wide 3 cycles. Minimum issue interval with rsp_ready_i tied high: narrow 3, wide 4.
- Arithmetic is modulo 2^WIDTH or 2^(2*WIDTH); overflow is not flagged.
- Requester inputs are sampled only at handshake. Later changes, or valid dropping without handshake, have no effect.
- rsp_valid_o stays high indefinitely while rsp_ready_i=0 (back-pressure); the FSM stalls in RESP.

Decomposition:
- Shared package lm32_addsub_pkg: state encodings (IDLE=2'd0, LO=2'd1, HI=2'd2, RESP=2'd3) and the WIDTH constant.
- Optional sub-module lm32_addsub_rr_arb: 2-way round-robin arbiter (valid0/1, advance → grant0/1).
- Adder instance stays outside this block.

Test Plan:
- Narrow add: req0 A=0x0000_0005, B=0x0000_0003, sub=0 → 2 cycles after accept: rsp_result_o=0x0000_0000_0000_0008, cout=0, id=0.
- Narrow subtract with borrow: req1 A=1, B=2, sub=1 → result=0x0000_0000_FFFF_FFFF, cout=0, id=1.
- Wide carry propagation: req0 wide A=0x0000_0000_FFFF_FFFF, B=0x1 → 3 cycles: result=0x0000_0001_0000_0000, cout=0.
  - Check add_cin_o=1 during HI.
- Both requesters valid continuously with rsp_ready_i=1 → grants alternate 0,1,0,1.
  - Each readiness pulses for exactly one cycle.
  - A single valid requester is granted on every IDLE.
- Back-pressure: rsp_ready_i=0 for 5 cycles in RESP → outputs stable, both readies 0; release → IDLE next cycle.
- Reset mid-op: rst_i low during HI of a wide op → all outputs 0 immediately (async), state IDLE.
  - Next grant after release goes to req0 when both are valid.
